// File: rtl/fmc_cmd_router_if.sv
// Command-side and external-target signal bundle for fmc_cmd_router.
// slave: the router's view; master: the fmc_slave / external-target side.
interface fmc_cmd_router_if;
    logic         i_cmd_sel;
    logic         i_cmd_rd_wr_n;
    logic [25:0]  i_cmd_byte_addr;
    logic [31:0]  i_cmd_wdata;
    logic         o_cmd_ack;
    logic [31:0]  o_cmd_rdata;
    logic         o_ext_req;
    logic         o_ext_rd_wr_n;
    logic [25:0]  o_ext_addr;
    logic [31:0]  o_ext_wdata;
    logic         i_ext_ack;
    logic [31:0]  i_ext_rdata;
    logic [127:0] o_ctrl_regs;

    modport slave (
        input  i_cmd_sel, i_cmd_rd_wr_n, i_cmd_byte_addr, i_cmd_wdata,
        output o_cmd_ack, o_cmd_rdata,
        output o_ext_req, o_ext_rd_wr_n, o_ext_addr, o_ext_wdata,
        input  i_ext_ack, i_ext_rdata,
        output o_ctrl_regs
    );

    modport master (
        output i_cmd_sel, i_cmd_rd_wr_n, i_cmd_byte_addr, i_cmd_wdata,
        input  o_cmd_ack, o_cmd_rdata,
        input  o_ext_req, o_ext_rd_wr_n, o_ext_addr, o_ext_wdata,
        output i_ext_ack, i_ext_rdata,
        input  o_ctrl_regs
    );
endinterface

// File: rtl/fmc_cmd_router.sv
// Routes fmc_slave commands to a local register bank (region 0) or an external target port.
// Define FMC_CMD_ROUTER_TIMEOUT_EN to build the external response timeout, STATUS[0] and TIMEOUT_COUNT.
module fmc_cmd_router #(
    parameter logic [31:0] VERSION       = 32'h0001_0000,
    parameter int unsigned TIMEOUT_CLKS  = 64,
    parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_DEAD
) (
    input logic              i_sys_clk,
    input logic              i_sys_rst,
    fmc_cmd_router_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOCAL, S_EXT_WAIT, S_RESP, S_RELEASE
    } state_t;

    state_t       state, state_nxt;
    logic         is_local;
    logic         accept;
    logic         timeout_hit;
    logic         local_wr;

    logic         loc_rd_q;
    logic         loc_valid_q;
    logic [2:0]   loc_word_q;
    logic [31:0]  wdata_q;
    logic [31:0]  rsp_data;
    logic [31:0]  scratch;
    logic [31:0]  ctrl [4];
    logic [31:0]  status_rd;
    logic [31:0]  count_rd;
    logic [31:0]  local_rdata;

    assign is_local = (bus.i_cmd_byte_addr[25:24] == 2'b00);
    assign accept   = (state == S_IDLE) && bus.i_cmd_sel;
    assign local_wr = (state == S_LOCAL) && !loc_rd_q && loc_valid_q;
    assign bus.o_ctrl_regs = {ctrl[3], ctrl[2], ctrl[1], ctrl[0]};

    always_comb begin
        state_nxt       = state;
        bus.o_cmd_ack   = 1'b0;
        bus.o_cmd_rdata = '0;
        bus.o_ext_req   = 1'b0;
        case (state)
            S_IDLE:     if (bus.i_cmd_sel) state_nxt = is_local ? S_LOCAL : S_EXT_WAIT;
            S_LOCAL: begin
                state_nxt       = S_RELEASE;
                bus.o_cmd_ack   = 1'b1;
                bus.o_cmd_rdata = local_rdata;
            end
            S_EXT_WAIT: begin
                bus.o_ext_req = 1'b1;
                if (bus.i_ext_ack || timeout_hit) state_nxt = S_RESP;
            end
            S_RESP: begin
                state_nxt       = S_RELEASE;
                bus.o_cmd_ack   = 1'b1;
                bus.o_cmd_rdata = rsp_data;
            end
            S_RELEASE:  if (!bus.i_cmd_sel) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        local_rdata = '0;
        if (loc_valid_q) begin
            case (loc_word_q)
                3'd0:    local_rdata = VERSION;
                3'd1:    local_rdata = scratch;
                3'd2:    local_rdata = status_rd;
                3'd3:    local_rdata = count_rd;
                default: local_rdata = ctrl[loc_word_q[1:0]];
            endcase
        end
    end

    // Local fields are captured on every accept; external outputs only on external accepts so they hold across local accesses.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state             <= S_IDLE;
            loc_rd_q          <= 1'b1;
            loc_valid_q       <= 1'b0;
            loc_word_q        <= '0;
            wdata_q           <= '0;
            rsp_data          <= '0;
            scratch           <= '0;
            ctrl              <= '{default: '0};
            bus.o_ext_rd_wr_n <= 1'b1;
            bus.o_ext_addr    <= '0;
            bus.o_ext_wdata   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                loc_rd_q    <= bus.i_cmd_rd_wr_n;
                loc_valid_q <= (bus.i_cmd_byte_addr[23:5] == '0);
                loc_word_q  <= bus.i_cmd_byte_addr[4:2];
                wdata_q     <= bus.i_cmd_wdata;
                if (!is_local) begin
                    bus.o_ext_rd_wr_n <= bus.i_cmd_rd_wr_n;
                    bus.o_ext_addr    <= bus.i_cmd_byte_addr;
                    bus.o_ext_wdata   <= bus.i_cmd_wdata;
                end
            end
            if (state == S_EXT_WAIT) begin
                if (bus.i_ext_ack)
                    rsp_data <= bus.i_ext_rdata;
                else if (timeout_hit)
                    rsp_data <= TIMEOUT_RDATA;
            end
            if (local_wr) begin
                if (loc_word_q == 3'd1)
                    scratch <= wdata_q;
                else if (loc_word_q[2])
                    ctrl[loc_word_q[1:0]] <= wdata_q;
            end
        end
    end

`ifdef FMC_CMD_ROUTER_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        sticky_to;
    logic [15:0] to_count;

    // wait_cnt is 0 in the first EXT_WAIT cycle, so expiry at TIMEOUT_CLKS-1 gives exactly TIMEOUT_CLKS request cycles.
    assign timeout_hit = (state == S_EXT_WAIT) && !bus.i_ext_ack &&
                         (wait_cnt == 16'(TIMEOUT_CLKS - 1));
    assign status_rd   = {31'b0, sticky_to};
    assign count_rd    = {16'b0, to_count};

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            wait_cnt  <= '0;
            sticky_to <= 1'b0;
            to_count  <= '0;
        end else begin
            wait_cnt <= (state == S_EXT_WAIT) ? wait_cnt + 16'd1 : '0;
            if (timeout_hit) begin
                sticky_to <= 1'b1;
                if (to_count != '1) to_count <= to_count + 16'd1;
            end else if (local_wr && loc_word_q == 3'd2 && wdata_q[0]) begin
                sticky_to <= 1'b0;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign status_rd   = '0;
    assign count_rd    = '0;
`endif

endmodule

// File: tb/tb_fmc_cmd_router.sv
// Directed bench for fmc_cmd_router: transaction-level model of the register map and handshake timing,
// checked every cycle on the falling edge, plus literal spot checks.
module tb_fmc_cmd_router;
    localparam logic [31:0] VER   = 32'h0001_0000;
    localparam int          TO    = 64;
    localparam logic [31:0] TO_RD = 32'hDEAD_DEAD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fmc_cmd_router_if bus();

    fmc_cmd_router #(
        .VERSION(VER),
        .TIMEOUT_CLKS(TO),
        .TIMEOUT_RDATA(TO_RD)
    ) dut (
        .i_sys_clk(clk),
        .i_sys_rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model state
    logic [31:0] m_scratch;
    logic [31:0] m_ctrl [4];
    logic        m_status;
    logic [15:0] m_tcount;

    // Per-cycle expectations, set by the stimulus just after each rising edge
    logic        chk_en      = 1'b0;
    logic        exp_ack     = 1'b0;
    logic        exp_rd_chk  = 1'b0;
    logic [31:0] exp_rdata   = '0;
    logic        exp_req     = 1'b0;
    logic        exp_ext_rw  = 1'b1;
    logic [25:0] exp_ext_addr = '0;
    logic [31:0] exp_ext_wd  = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_scratch = '0;
        m_ctrl    = '{default: '0};
        m_status  = 1'b0;
        m_tcount  = '0;
        exp_ext_rw   = 1'b1;
        exp_ext_addr = '0;
        exp_ext_wd   = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [25:0] a);
        logic [2:0] w;
        w = a[4:2];
        if (a[23:5] != '0) return '0;
        case (w)
            3'd0: return VER;
            3'd1: return m_scratch;
`ifdef FMC_CMD_ROUTER_TIMEOUT_EN
            3'd2: return {31'b0, m_status};
            3'd3: return {16'b0, m_tcount};
`else
            3'd2: return '0;
            3'd3: return '0;
`endif
            default: return m_ctrl[w - 3'd4];
        endcase
    endfunction

    task automatic model_write(input logic [25:0] a, input logic [31:0] d);
        logic [2:0] w;
        w = a[4:2];
        if (a[23:5] == '0) begin
            if (w == 3'd1) m_scratch = d;
`ifdef FMC_CMD_ROUTER_TIMEOUT_EN
            if (w == 3'd2 && d[0]) m_status = 1'b0;
`endif
            if (w >= 3'd4) m_ctrl[w - 3'd4] = d;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ack", 128'(bus.o_cmd_ack), 128'(exp_ack));
            if (exp_ack && exp_rd_chk) chk("cmd_rdata", 128'(bus.o_cmd_rdata), 128'(exp_rdata));
            chk("ext_req", 128'(bus.o_ext_req), 128'(exp_req));
            chk("ext_rd_wr_n", 128'(bus.o_ext_rd_wr_n), 128'(exp_ext_rw));
            chk("ext_addr", 128'(bus.o_ext_addr), 128'(exp_ext_addr));
            chk("ext_wdata", 128'(bus.o_ext_wdata), 128'(exp_ext_wd));
            chk("ctrl_regs", bus.o_ctrl_regs, {m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]});
        end
    end

    task automatic local_txn(input logic rd, input logic [25:0] a, input logic [31:0] wd,
                             input int hold, output logic [31:0] rdat);
        bus.i_cmd_sel = 1'b1; bus.i_cmd_rd_wr_n = rd; bus.i_cmd_byte_addr = a; bus.i_cmd_wdata = wd;
        tick();
        exp_ack = 1'b1; exp_rd_chk = rd; exp_rdata = model_read(a);
        rdat = bus.o_cmd_rdata;
        bus.i_cmd_rd_wr_n = ~rd; bus.i_cmd_byte_addr = ~a; bus.i_cmd_wdata = ~wd;
        tick();
        exp_ack = 1'b0;
        if (!rd) model_write(a, wd);
        repeat (hold) tick();
        bus.i_cmd_sel = 1'b0;
        tick();
    endtask

    task automatic ext_txn(input logic rd, input logic [25:0] a, input logic [31:0] wd,
                           input int ack_after, input logic [31:0] resp,
                           input int hold, output logic [31:0] rdat, output int req_cycles);
        logic timed;
        int   ncyc;
`ifdef FMC_CMD_ROUTER_TIMEOUT_EN
        timed = (ack_after == 0) || (ack_after > TO);
`else
        timed = 1'b0;
`endif
        ncyc = timed ? TO : ack_after;
        req_cycles = 0;
        bus.i_cmd_sel = 1'b1; bus.i_cmd_rd_wr_n = rd; bus.i_cmd_byte_addr = a; bus.i_cmd_wdata = wd;
        tick();
        exp_req = 1'b1; exp_ext_rw = rd; exp_ext_addr = a; exp_ext_wd = wd;
        bus.i_cmd_rd_wr_n = ~rd; bus.i_cmd_byte_addr = ~a; bus.i_cmd_wdata = ~wd;
        for (int i = 1; i <= ncyc; i++) begin
            if (bus.o_ext_req) req_cycles++;
            if (!timed && i == ncyc) begin
                bus.i_ext_ack = 1'b1; bus.i_ext_rdata = resp;
            end else begin
                bus.i_ext_rdata = $urandom;
            end
            tick();
        end
        bus.i_ext_ack = 1'b0; bus.i_ext_rdata = $urandom;
        exp_req = 1'b0; exp_ack = 1'b1; exp_rd_chk = rd;
        exp_rdata = timed ? TO_RD : resp;
        rdat = bus.o_cmd_rdata;
        if (timed) begin
            m_status = 1'b1;
            if (m_tcount != 16'hFFFF) m_tcount = m_tcount + 16'd1;
        end
        tick();
        exp_ack = 1'b0;
        repeat (hold) tick();
        bus.i_cmd_sel = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int          rc;
        bus.i_cmd_sel = 1'b0; bus.i_cmd_rd_wr_n = 1'b1; bus.i_cmd_byte_addr = '0; bus.i_cmd_wdata = '0;
        bus.i_ext_ack = 1'b0; bus.i_ext_rdata = '0;
        model_reset();
        tick();
        chk_en = 1'b1;
        chk("rst_cmd_rdata", 128'(bus.o_cmd_rdata), 128'(32'h0));
        chk("rst_ctrl", bus.o_ctrl_regs, 128'h0);
        tick(); tick();
        rst = 1'b0;
        tick();

        local_txn(1'b1, 26'h0000000, 32'h0, 0, r);
        chk("lit_version", 128'(r), 128'(32'h0001_0000));
        local_txn(1'b0, 26'h0000004, 32'hCAFE_BABE, 0, r);
        local_txn(1'b1, 26'h0000004, 32'h0, 0, r);
        chk("lit_scratch", 128'(r), 128'(32'hCAFE_BABE));
        local_txn(1'b0, 26'h0000010, 32'hA5A5_A5A5, 0, r);
        chk("lit_ctrl4", 128'(bus.o_ctrl_regs[31:0]), 128'(32'hA5A5_A5A5));
        local_txn(1'b1, 26'h0000020, 32'h0, 0, r);
        chk("lit_oor_read", 128'(r), 128'(32'h0));
        local_txn(1'b0, 26'h0000024, 32'h1111_1111, 0, r);
        local_txn(1'b1, 26'h0000004, 32'h0, 0, r);
        chk("lit_oor_write_dropped", 128'(r), 128'(32'hCAFE_BABE));
        local_txn(1'b0, 26'h000001C, 32'h0F0F_0F0F, 0, r);
        local_txn(1'b1, 26'h000001F, 32'h0, 0, r);
        chk("lit_ctrl7_lowbits", 128'(r), 128'(32'h0F0F_0F0F));
        local_txn(1'b0, 26'h0000000, 32'h5555_5555, 0, r);
        local_txn(1'b1, 26'h0000000, 32'h0, 0, r);
        chk("lit_version_ro", 128'(r), 128'(32'h0001_0000));

        ext_txn(1'b0, 26'h1000010, 32'hDEAD_BEEF, 5, 32'h0, 0, r, rc);
        chk("lit_ext_req_cycles", 128'(rc), 128'(5));
        chk("lit_ext_addr_hold", 128'(bus.o_ext_addr), 128'(26'h1000010));
        ext_txn(1'b1, 26'h2000008, 32'h0, 1, 32'h1234_5678, 0, r, rc);
        chk("lit_ext_rdata", 128'(r), 128'(32'h1234_5678));
        local_txn(1'b0, 26'h0000014, 32'h0BAD_F00D, 0, r);
        chk("lit_ext_hold_local", 128'(bus.o_ext_addr), 128'(26'h2000008));

`ifdef FMC_CMD_ROUTER_TIMEOUT_EN
        ext_txn(1'b1, 26'h3000000, 32'h0, 0, 32'h0, 0, r, rc);
        chk("lit_to_rdata", 128'(r), 128'(32'hDEAD_DEAD));
        chk("lit_to_req_cycles", 128'(rc), 128'(64));
        local_txn(1'b1, 26'h0000008, 32'h0, 0, r);
        chk("lit_status_set", 128'(r), 128'(32'h1));
        local_txn(1'b1, 26'h000000C, 32'h0, 0, r);
        chk("lit_to_count", 128'(r), 128'(32'h1));
        ext_txn(1'b1, 26'h3000004, 32'h0, 64, 32'hA0A0_A0A0, 0, r, rc);
        chk("lit_ack_at_expiry", 128'(r), 128'(32'hA0A0_A0A0));
        ext_txn(1'b0, 26'h3000008, 32'h7777_7777, 0, 32'h0, 0, r, rc);
        local_txn(1'b1, 26'h000000C, 32'h0, 0, r);
        chk("lit_to_count2", 128'(r), 128'(32'h2));
        local_txn(1'b0, 26'h0000008, 32'h1, 0, r);
        local_txn(1'b1, 26'h0000008, 32'h0, 0, r);
        chk("lit_status_w1c", 128'(r), 128'(32'h0));
`else
        local_txn(1'b0, 26'h0000008, 32'hFFFF_FFFF, 0, r);
        local_txn(1'b1, 26'h0000008, 32'h0, 0, r);
        chk("lit_status_off", 128'(r), 128'(32'h0));
        local_txn(1'b1, 26'h000000C, 32'h0, 0, r);
        chk("lit_tcount_off", 128'(r), 128'(32'h0));
        ext_txn(1'b1, 26'h3000000, 32'h0, 90, 32'h600D_600D, 0, r, rc);
        chk("lit_no_timeout", 128'(r), 128'(32'h600D_600D));
`endif

        local_txn(1'b1, 26'h0000004, 32'h0, 10, r);
        ext_txn(1'b1, 26'h1000100, 32'h0, 2, 32'hBEEF_0001, 10, r, rc);

        // Reset during EXT_WAIT: request drops, no ack, late target ack ignored.
        bus.i_cmd_sel = 1'b1; bus.i_cmd_rd_wr_n = 1'b1; bus.i_cmd_byte_addr = 26'h1000200; bus.i_cmd_wdata = '0;
        tick();
        exp_req = 1'b1; exp_ext_rw = 1'b1; exp_ext_addr = 26'h1000200; exp_ext_wd = '0;
        tick(); tick();
        rst = 1'b1; bus.i_cmd_sel = 1'b0;
        tick();
        model_reset();
        exp_req = 1'b0;
        rst = 1'b0; bus.i_ext_ack = 1'b1; bus.i_ext_rdata = 32'h0BAD_0BAD;
        tick();
        bus.i_ext_ack = 1'b0;
        tick(); tick();
        local_txn(1'b1, 26'h0000004, 32'h0, 0, r);
        chk("lit_scratch_after_rst", 128'(r), 128'(32'h0));
        ext_txn(1'b1, 26'h2000040, 32'h0, 3, 32'hFACE_CAFE, 0, r, rc);
        chk("lit_ext_after_rst", 128'(r), 128'(32'hFACE_CAFE));
        tick(); tick();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fmc_cmd_router.md
# fmc_cmd_router

Command-side consumer of `fmc_slave`: accepts its single-outstanding `sel/ack` command stream and decodes the 26-bit byte address. Region 0 is served by a local register bank (version, scratch, status, control outputs); all other regions are forwarded to an external target port guarded by a response timeout. Sits between `fmc_slave` and the rest of the command-and-control fabric.

## Interface
Parameters:
- `VERSION`, 32'h0001_0000, value returned by local reg 0
- `TIMEOUT_CLKS`, 64, external wait limit in `i_sys_clk` cycles (2..65535)
- `TIMEOUT_RDATA`, 32'hDEAD_DEAD, read data returned on timeout

Ports:
- `i_sys_clk` in 1 — sole clock
- `i_sys_rst` in 1 — synchronous, active-high reset
- `i_cmd_sel` in 1 — command valid, level, held by `fmc_slave` until ack
- `i_cmd_rd_wr_n` in 1 — 1 = read, 0 = write
- `i_cmd_byte_addr` in 26 — byte address
- `i_cmd_wdata` in 32 — write data
- `o_cmd_ack` out 1 — one-cycle completion pulse
- `o_cmd_rdata` out 32 — read data, valid while `o_cmd_ack`=1
- `o_ext_req` out 1 — external request, level
- `o_ext_rd_wr_n` out 1 — external direction
- `o_ext_addr` out 26 — external byte address
- `o_ext_wdata` out 32 — external write data
- `i_ext_ack` in 1 — external completion pulse
- `i_ext_rdata` in 32 — external read data, valid with `i_ext_ack`
- `o_ctrl_regs` out 128 — local regs 4..7, reg 4 in [31:0]

## Operation
- Decode: `addr[25:24]`==0 → local; otherwise → external. `addr[1:0]` ignored.
- Local map (word index `addr[4:2]`, valid only when `addr[23:5]`==0; else read 0, write dropped): 0 VERSION (RO); 1 SCRATCH (RW); 2 STATUS, bit0 = sticky timeout, write-1-to-clear, bits[31:1] read 0; 3 TIMEOUT_COUNT, [15:0] saturating at 0xFFFF, RO; 4–7 CTRL (RW, drive `o_ctrl_regs`).
- FSM: IDLE → (sel, local) LOCAL → RELEASE; IDLE → (sel, external) EXT_WAIT → RESP → RELEASE; RELEASE → IDLE when `i_cmd_sel`=0.
- Command fields are captured on the IDLE→ exit edge; later input changes ignored.
- EXT_WAIT: `o_ext_req`=1 with captured fields until `i_ext_ack` sampled high; `i_ext_rdata` captured then. Ack in the same cycle as timeout expiry wins (no error).
- Timeout: counter reaches `TIMEOUT_CLKS` with no ack → drop `o_ext_req`, read data = `TIMEOUT_RDATA`, set STATUS[0], increment TIMEOUT_COUNT, go to RESP. Writes are acked normally.
- A set from timeout in the same cycle as a W1C on STATUS[0]: set wins.
- `o_ext_req` never asserts during local access; `o_ext_*` fields hold last values when idle.

## Timing
- Reset values: `o_cmd_ack`=0, `o_cmd_rdata`=0, `o_ext_req`=0, `o_ext_rd_wr_n`=1, `o_ext_addr`=0, `o_ext_wdata`=0, `o_ctrl_regs`=0; SCRATCH, STATUS, TIMEOUT_COUNT = 0; FSM = IDLE.
- Local: `i_cmd_sel` sampled high in IDLE at edge N → `o_cmd_ack`=1 during cycle N+1; write committed at edge N+1.
- External: `o_ext_req` high from cycle N+1; `i_ext_ack` sampled at edge M → `o_cmd_ack`=1 during cycle M+1; `o_ext_req` low from cycle M+1.
- Timeout: `o_ext_req` high for exactly `TIMEOUT_CLKS` cycles; ack cycle follows immediately.
- `o_cmd_ack` is exactly one cycle; no new command accepted until `i_cmd_sel` seen low (RELEASE).
- Reset mid-transaction: returns to IDLE next edge, `o_ext_req` dropped, no ack issued, late `i_ext_ack` ignored.

## Configuration
- `FMC_CMD_ROUTER_TIMEOUT_EN` defined: timeout logic, STATUS[0] and TIMEOUT_COUNT as above.
- Undefined: EXT_WAIT waits indefinitely for `i_ext_ack`; STATUS and TIMEOUT_COUNT read 0, writes ignored; no timeout counter synthesised.

## Test plan
- Reset, read addr 0x0000000 → ack 1 cycle after sel, rdata 0x00010000; all outputs at reset values beforehand.
- Write 0x0000004 = 0xCAFEBABE, read back → 0xCAFEBABE; write 0x0000010 = 0xA5A5A5A5 → `o_ctrl_regs[31:0]`=0xA5A5A5A5; read 0x0000020 → 0.
- Write 0x1000010 = 0xDEADBEEF, target acks after 5 cycles → `o_ext_req` high 5 cycles, addr 0x1000010, wdata 0xDEADBEEF; `o_cmd_ack` next cycle.
- Read 0x2000008, target returns 0x12345678 → `o_cmd_rdata`=0x12345678 with ack.
- (TIMEOUT_EN) read 0x3000000, no ext ack → req low after 64 cycles, rdata 0xDEADDEAD, STATUS=1, TIMEOUT_COUNT=1; write 0x0000008 = 1 → STATUS=0.
- Hold `i_cmd_sel` high 10 cycles after ack → single ack only; assert `i_sys_rst` during EXT_WAIT → req drops, no ack, next command served normally.
